// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
// - state_t         : FSM state encodings (FETCH = 0 so a reset-gated state_dbg reads FETCH)
// - opcode / funct  : instruction field values recognised by the decoder
// - control codes   : pc_src, alu_imm_sel, reg_dst, wb_sel mux selects
// - instr_class_t   : one-hot-ish classification produced by mips_instr_class
// - ctrl_t          : bundle of every datapath control output
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LL    = 6'h30;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type functs
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // mux selects
  localparam logic [1:0] PC_SRC_SEQ   = 2'd0;
  localparam logic [1:0] PC_SRC_BR    = 2'd1;
  localparam logic [1:0] PC_SRC_JMP   = 2'd2;
  localparam logic [1:0] IMM_SEL_IR   = 2'd0;
  localparam logic [1:0] IMM_SEL_4    = 2'd1;
  localparam logic [1:0] IMM_SEL_SHL2 = 2'd2;
  localparam logic [1:0] REG_DST_RT   = 2'd0;
  localparam logic [1:0] REG_DST_RD   = 2'd1;
  localparam logic [1:0] REG_DST_RA   = 2'd2;
  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_MEM   = 2'd1;
  localparam logic [1:0] WB_SEL_PC    = 2'd2;

  typedef struct packed {
    logic is_r;
    logic is_alui;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_illegal;
  } instr_class_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_imm_sel;
    logic [5:0] alu_opcode;
    logic [5:0] alu_funct;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       illegal_instr;
  } ctrl_t;

endpackage

// File: rtl/mips_instr_class.sv
// Combinational instruction classifier.
// Ports:
//   instr_opcode in  6  IR[31:26]
//   instr_funct  in  6  IR[5:0]
//   cls          out    instr_class_t; exactly one bit set for any input
module mips_instr_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   instr_opcode,
  input  logic [5:0]   instr_funct,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    if (instr_opcode == OP_RTYPE) begin
      if (instr_funct inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                              FN_NOR, FN_SLL, FN_SRL, FN_SRA, FN_SLT, FN_SLTU})
        cls.is_r = 1'b1;
      else
        cls.is_illegal = 1'b1;
    end else if (instr_opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                                      OP_ANDI, OP_ORI, OP_LUI}) begin
      cls.is_alui = 1'b1;
    end else if (instr_opcode inside {OP_LW, OP_LBU, OP_LHU, OP_LL}) begin
      cls.is_load = 1'b1;
    end else if (instr_opcode inside {OP_SB, OP_SH, OP_SW}) begin
      cls.is_store = 1'b1;
    end else if (instr_opcode inside {OP_BEQ, OP_BNE}) begin
      cls.is_branch = 1'b1;
    end else if (instr_opcode inside {OP_J, OP_JAL}) begin
      cls.is_jump = 1'b1;
    end else begin
      cls.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU opcode/funct plus datapath enables. One instruction in flight.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   instr_opcode, instr_funct  IR fields (valid from DECODE onward)
//   sig_branch                 ALU branch-taken flag (used in BRANCH)
//   mem_ready                  memory completes current request this cycle
//   mem_req, mem_we            memory request / write
//   ir_write, pc_write, pc_src IR and PC update controls
//   alu_src_a, alu_imm_sel     ALU operand selects
//   alu_opcode, alu_funct      ALU operation
//   reg_write, reg_dst, wb_sel register file writeback controls
//   illegal_instr              unsupported instruction (TRAP)
//   state_dbg                  current state encoding
// While rst is high every output is gated to 0 so no memory write can escape.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit TRAP_HALT = 1'b0,
  parameter int STATE_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         instr_opcode,
  input  logic [5:0]         instr_funct,
  input  logic               sig_branch,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_imm_sel,
  output logic [5:0]         alu_opcode,
  output logic [5:0]         alu_funct,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  state_t       state;
  instr_class_t cls;
  ctrl_t        ctrl, ctrl_g;

  mips_instr_class u_cls (
    .instr_opcode (instr_opcode),
    .instr_funct  (instr_funct),
    .cls          (cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if      (cls.is_illegal)               state <= S_TRAP;
          else if (cls.is_r)                     state <= S_EXEC_R;
          else if (cls.is_alui)                  state <= S_EXEC_I;
          else if (cls.is_load || cls.is_store)  state <= S_MEMADR;
          else if (cls.is_branch)                state <= S_BRANCH;
          else if (cls.is_jump)                  state <= S_JUMP;
          else                                   state <= S_TRAP;
        end
        // only loads and stores reach MEMADR
        S_MEMADR: state <= cls.is_store ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC_R: state <= S_RWB;
        S_EXEC_I: state <= S_IWB;
        S_TRAP:   if (!TRAP_HALT) state <= S_FETCH;
        default:  state <= S_FETCH;  // MEMWB, RWB, IWB, BRANCH, JUMP, unused codes
      endcase
    end
  end

  // Output decode from the state register. ir_write/pc_write in FETCH follow
  // mem_ready so the IR and PC update only on the cycle the fetch completes.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req     = 1'b1;
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_imm_sel = IMM_SEL_4;
        ctrl.alu_opcode  = OP_ADDIU;
        ctrl.ir_write    = mem_ready;
        ctrl.pc_write    = mem_ready;
        ctrl.pc_src      = PC_SRC_SEQ;
      end
      S_DECODE: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_imm_sel = IMM_SEL_SHL2;
        ctrl.alu_opcode  = OP_ADDIU;
      end
      S_MEMADR: begin
        ctrl.alu_opcode  = instr_opcode;
        ctrl.alu_imm_sel = IMM_SEL_IR;
      end
      S_MEMRD:  ctrl.mem_req = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REG_DST_RT;
        ctrl.wb_sel    = WB_SEL_MEM;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_opcode = OP_RTYPE;
        ctrl.alu_funct  = instr_funct;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REG_DST_RD;
        ctrl.wb_sel    = WB_SEL_ALU;
      end
      S_EXEC_I: begin
        ctrl.alu_opcode  = instr_opcode;
        ctrl.alu_imm_sel = IMM_SEL_IR;
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REG_DST_RT;
        ctrl.wb_sel    = WB_SEL_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_opcode = instr_opcode;
        ctrl.pc_write   = sig_branch;
        ctrl.pc_src     = PC_SRC_BR;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JMP;
        if (instr_opcode == OP_JAL) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = REG_DST_RA;
          ctrl.wb_sel    = WB_SEL_PC;
        end
      end
      S_TRAP:  ctrl.illegal_instr = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign ctrl_g = rst ? '0 : ctrl;

  assign mem_req       = ctrl_g.mem_req;
  assign mem_we        = ctrl_g.mem_we;
  assign ir_write      = ctrl_g.ir_write;
  assign pc_write      = ctrl_g.pc_write;
  assign pc_src        = ctrl_g.pc_src;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_imm_sel   = ctrl_g.alu_imm_sel;
  assign alu_opcode    = ctrl_g.alu_opcode;
  assign alu_funct     = ctrl_g.alu_funct;
  assign reg_write     = ctrl_g.reg_write;
  assign reg_dst       = ctrl_g.reg_dst;
  assign wb_sel        = ctrl_g.wb_sel;
  assign illegal_instr = ctrl_g.illegal_instr;
  assign state_dbg     = rst ? '0 : STATE_W'(state);

endmodule
